// File: rtl/proj_pkg.sv
// Shared types and constants for the FM fetch path.
// Defines the signature/index request payload, the FM buffer lifecycle states,
// the per-buffer metadata record, the issue FSM states, and the packet
// address shift used to turn a packet index into an FM byte offset.
package proj_pkg;

    localparam int HASHER_EXTENDER_INDICES_COUNT = 4;
    localparam int FM_BUFFER_COUNT               = 2;
    localparam int FM_EXTENDER_BASES_READ_COUNT  = 256;
    localparam int FM_PACKET_SHIFT               = $clog2(FM_EXTENDER_BASES_READ_COUNT);

    localparam int SIG_W   = 16;
    localparam int INDEX_W = 16;
    localparam int LANE_W  = $clog2(HASHER_EXTENDER_INDICES_COUNT);

    typedef struct packed {
        logic [SIG_W-1:0]   signature;
        logic [INDEX_W-1:0] index;
    } signature_index_pack_t;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        FETCHING = 2'd1,
        FILLED   = 2'd2,
        IN_USE   = 2'd3
    } fm_buf_state_e;

    typedef struct packed {
        logic [LANE_W-1:0]     lane;
        signature_index_pack_t pack;
    } fm_fetch_meta_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } fetch_fsm_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// Ports: req (N request bits), ptr (highest-priority index), gnt (one-hot grant,
// zero when no request). The search starts at ptr and walks upward with wrap.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fm_fetch_scheduler.sv
// FM packet fetch scheduler.
// Grants one requesting lane at a time (round-robin) into the lowest free FM
// buffer, issues the packet read to the FM, and offers filled buffers to the
// extender strictly in grant order via an inline order FIFO.
// Ports: clk/rst_n; base_addr; req_valid/req_pack/req_ready (lane requests);
// fm_rd_* (read issue), fm_done_* (fill completion); ext_valid/ext_ready/
// ext_buf/ext_lane/ext_pack (delivery); ext_release* (buffer return);
// busy (any buffer in use or read pending); err (sticky protocol error).
module fm_fetch_scheduler
    import proj_pkg::*;
#(
    parameter int NUM_REQ = HASHER_EXTENDER_INDICES_COUNT,
    parameter int NUM_BUF = FM_BUFFER_COUNT,
    parameter int ADDR_W  = 32,
    localparam int BW = $clog2(NUM_BUF),
    localparam int LW = $clog2(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [ADDR_W-1:0]                   base_addr,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  signature_index_pack_t [NUM_REQ-1:0] req_pack,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                fm_rd_valid,
    input  logic                                fm_rd_ready,
    output logic [ADDR_W-1:0]                   fm_rd_addr,
    output logic [BW-1:0]                       fm_rd_buf,
    input  logic                                fm_done_valid,
    input  logic [BW-1:0]                       fm_done_buf,
    output logic                                ext_valid,
    input  logic                                ext_ready,
    output logic [BW-1:0]                       ext_buf,
    output logic [LW-1:0]                       ext_lane,
    output signature_index_pack_t               ext_pack,
    input  logic                                ext_release,
    input  logic [BW-1:0]                       ext_release_buf,
    output logic                                busy,
    output logic                                err
);

    fetch_fsm_e     fsm;
    fm_buf_state_e  buf_st   [NUM_BUF];
    fm_buf_state_e  buf_st_n [NUM_BUF];
    fm_fetch_meta_t meta     [NUM_BUF];
    fm_fetch_meta_t meta_n   [NUM_BUF];
    logic [BW-1:0]  fifo     [NUM_BUF];
    logic [BW-1:0]  fifo_n   [NUM_BUF];
    logic [BW-1:0]  rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
    logic [BW:0]    count, count_n;
    logic [LW-1:0]  rr_ptr;

    logic               any_free, grant_en, grant, deliver, err_set;
    logic               issue_n, ext_valid_n, busy_n;
    logic [BW-1:0]      free_idx, head_n;
    logic [LW-1:0]      winner;
    logic [NUM_REQ-1:0] req_masked, gnt;

    function automatic logic [BW-1:0] buf_ptr_inc(input logic [BW-1:0] p);
        return (p == BW'(NUM_BUF - 1)) ? '0 : p + 1'b1;
    endfunction

    // Lowest-index FREE buffer, from registered state only, so a buffer
    // released this cycle becomes grantable one cycle later.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if (buf_st[i] == FREE) begin
                any_free = 1'b1;
                free_idx = BW'(i);
            end
        end
    end

    // Grants are suppressed while in reset so every output reads 0 there.
    assign grant_en   = rst_n && (fsm == IDLE) && any_free;
    assign req_masked = req_valid & {NUM_REQ{grant_en}};

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req (req_masked),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign grant     = |gnt;

    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) winner = LW'(i);
        end
    end

    // Next buffer/FIFO state. Each event acts only on a buffer in the state it
    // expects, so the four transitions can never collide on one buffer.
    always_comb begin
        buf_st_n = buf_st;
        meta_n   = meta;
        fifo_n   = fifo;
        rd_ptr_n = rd_ptr;
        wr_ptr_n = wr_ptr;
        err_set  = 1'b0;
        deliver  = ext_valid && ext_ready;

        if (grant) begin
            buf_st_n[free_idx] = FETCHING;
            meta_n[free_idx]   = '{lane: LANE_W'(winner), pack: req_pack[winner]};
            fifo_n[wr_ptr]     = free_idx;
            wr_ptr_n           = buf_ptr_inc(wr_ptr);
        end
        if (fm_done_valid) begin
            if (buf_st[fm_done_buf] == FETCHING) buf_st_n[fm_done_buf] = FILLED;
            else                                 err_set = 1'b1;
        end
        if (deliver) begin
            buf_st_n[fifo[rd_ptr]] = IN_USE;
            rd_ptr_n               = buf_ptr_inc(rd_ptr);
        end
        if (ext_release) begin
            if (buf_st[ext_release_buf] == IN_USE) buf_st_n[ext_release_buf] = FREE;
            else                                   err_set = 1'b1;
        end

        count_n     = count + (BW+1)'(grant) - (BW+1)'(deliver);
        head_n      = fifo_n[rd_ptr_n];
        ext_valid_n = (count_n != '0) && (buf_st_n[head_n] == FILLED);
        issue_n     = (fsm == IDLE) ? grant : !fm_rd_ready;

        busy_n = issue_n;
        for (int i = 0; i < NUM_BUF; i++) begin
            if (buf_st_n[i] != FREE) busy_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            rr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < NUM_BUF; i++) begin
                buf_st[i] <= FREE;
                meta[i]   <= '0;
                fifo[i]   <= '0;
            end
            fm_rd_valid <= 1'b0;
            fm_rd_addr  <= '0;
            fm_rd_buf   <= '0;
            ext_valid   <= 1'b0;
            ext_buf     <= '0;
            ext_lane    <= '0;
            ext_pack    <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            buf_st    <= buf_st_n;
            meta      <= meta_n;
            fifo      <= fifo_n;
            rd_ptr    <= rd_ptr_n;
            wr_ptr    <= wr_ptr_n;
            count     <= count_n;
            ext_valid <= ext_valid_n;
            ext_buf   <= head_n;
            ext_lane  <= LW'(meta_n[head_n].lane);
            ext_pack  <= meta_n[head_n].pack;
            busy      <= busy_n;
            err       <= err | err_set;

            case (fsm)
                IDLE: begin
                    if (grant) begin
                        fsm         <= ISSUE;
                        rr_ptr      <= (winner == LW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                        fm_rd_valid <= 1'b1;
                        // Sum wraps at ADDR_W; an overflowing address is not an error.
                        fm_rd_addr  <= base_addr
                                     + (ADDR_W'(req_pack[winner].index) << FM_PACKET_SHIFT);
                        fm_rd_buf   <= free_idx;
                    end
                end
                ISSUE: begin
                    if (fm_rd_ready) begin
                        fsm         <= IDLE;
                        fm_rd_valid <= 1'b0;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule
